// File: rtl/ddr3_frame_reader_pkg.sv
// Shared definitions for the DDR3 frame read path: command codes, bus widths and FSM states.
package ddr3_frame_reader_pkg;

    localparam int DDR3_ADDR_W     = 28;
    localparam int DDR3_DATA_W     = 128;
    localparam int DDR3_LEN_W      = 16;
    localparam int DDR3_FIFO_DEPTH = 32;
    localparam int DDR3_ADDR_STEP  = 8;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/ddr3_frame_reader_fifo.sv
// First-word-fall-through FIFO with a registered output stage; count_o includes the output register.
module sync_fifo_fwft #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     ready_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    mem_cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    logic pop;
    logic out_free;
    logic bypass;
    logic load;
    logic mem_wr;

    assign pop      = valid_q & ready_i;
    assign out_free = ~valid_q | pop;
    // An empty store lets a push go straight to the output register, so valid rises one cycle after the push.
    assign bypass   = push_i & (mem_cnt_q == '0) & out_free;
    assign load     = (mem_cnt_q != '0) & out_free;
    assign mem_wr   = push_i & ~bypass;

    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (load) begin
                data_q   <= mem_q[rd_ptr_q];
                valid_q  <= 1'b1;
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else if (bypass) begin
                data_q  <= data_i;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
            case ({mem_wr, load})
                2'b10:   mem_cnt_q <= mem_cnt_q + (PTR_W+1)'(1);
                2'b01:   mem_cnt_q <= mem_cnt_q - (PTR_W+1)'(1);
                default: mem_cnt_q <= mem_cnt_q;
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = mem_cnt_q + (PTR_W+1)'(valid_q);
    assign full_o  = (count_o == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_o == '0);

endmodule

// File: rtl/ddr3_frame_reader.sv
// Streams a stored frame out of DDR3: issues credit-limited BL8 reads and forwards returned beats with valid/ready.
module ddr3_frame_reader
    import ddr3_frame_reader_pkg::*;
#(
    parameter int         ADDR_W     = DDR3_ADDR_W,
    parameter int         DATA_W     = DDR3_DATA_W,
    parameter int         LEN_W      = DDR3_LEN_W,
    parameter int         FIFO_DEPTH = DDR3_FIFO_DEPTH,
    parameter int         ADDR_STEP  = DDR3_ADDR_STEP,
    parameter logic [2:0] CMD_CODE   = CMD_RD
) (
    input  logic              i_ddr3_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_start,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [LEN_W-1:0]  i_rd_len,
    output logic              o_rd_busy,
    output logic              o_rd_done,
    output logic              o_rd_err,
    output logic [2:0]        o_ddr3_cmd,
    output logic              o_ddr3_cmd_en,
    output logic [ADDR_W-1:0] o_ddr3_addr,
    input  logic              i_ddr3_cmd_ready,
    input  logic [DATA_W-1:0] i_ddr3_rd_data,
    input  logic              i_ddr3_rd_data_de,
    input  logic              i_ddr3_rd_data_end,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_data_last,
    input  logic              i_data_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  recv_q;
    logic [LEN_W-1:0]  out_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [LEN_W-1:0]  issued_d;
    logic [LEN_W-1:0]  outstanding_full;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_sum;
    logic              credit_ok;
    logic              cmd_en;
    logic              start_acc;
    logic              push;
    logic              pop;
    logic              last;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;

    assign issued_d         = issued_q + LEN_W'(1);
    // Credit keeps outstanding <= FIFO_DEPTH, so the low bits of the difference are exact.
    assign outstanding_full = issued_q - recv_q;
    assign outstanding      = outstanding_full[CNT_W-1:0];
    assign credit_sum       = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok        = (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
    assign cmd_en           = (state_q == ISSUE) & credit_ok & i_ddr3_cmd_ready;
    assign start_acc        = i_rd_start & ~busy_q;
    assign push             = i_ddr3_rd_data_de & (outstanding != '0);
    assign pop              = fifo_valid & i_data_ready;
    assign last             = fifo_valid & (out_q == len_q - LEN_W'(1));

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_ddr3_clk),
        .rst_ni  (i_rst_n),
        .push_i  (push),
        .data_i  (i_ddr3_rd_data),
        .ready_i (i_data_ready),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push) begin
                recv_q <= recv_q + LEN_W'(1);
            end
            if (i_ddr3_rd_data_de && !push) begin
                err_q <= 1'b1;
            end
            if (pop) begin
                out_q <= out_q + LEN_W'(1);
            end
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start_acc) begin
                        if (i_rd_len != '0) begin
                            state_q  <= ISSUE;
                            addr_q   <= i_rd_addr;
                            len_q    <= i_rd_len;
                            issued_q <= '0;
                            recv_q   <= '0;
                            out_q    <= '0;
                            busy_q   <= 1'b1;
                            // A stray beat in the start cycle still counts as an error.
                            err_q    <= i_ddr3_rd_data_de & ~push;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_en) begin
                        addr_q   <= addr_q + ADDR_W'(ADDR_STEP);
                        issued_q <= issued_d;
                        if (issued_d == len_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last && (recv_q == len_q)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rd_busy     = busy_q;
    assign o_rd_done     = done_q;
    assign o_rd_err      = err_q;
    assign o_ddr3_cmd    = CMD_CODE;
    assign o_ddr3_cmd_en = cmd_en;
    assign o_ddr3_addr   = addr_q;
    assign o_data        = fifo_data;
    assign o_data_valid  = fifo_valid;
    assign o_data_last   = last;

    logic unused_ok;
    assign unused_ok = &{1'b0, i_ddr3_rd_data_end, fifo_full, fifo_empty,
                         outstanding_full[LEN_W-1:CNT_W]};

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Scoreboard bench for ddr3_frame_reader: DDR3 memory/latency model, expected-beat queue and a decoupled output monitor.
module tb_ddr3_frame_reader;
    import ddr3_frame_reader_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          rd_start;
    logic [27:0]   rd_addr;
    logic [15:0]   rd_len;
    logic          rd_busy, rd_done, rd_err;
    logic [2:0]    ddr3_cmd;
    logic          ddr3_cmd_en;
    logic [27:0]   ddr3_addr;
    logic          ddr3_cmd_ready;
    logic [127:0]  ddr3_rd_data;
    logic          ddr3_rd_de;
    logic          ddr3_rd_end;
    logic [127:0]  data;
    logic          data_valid, data_last;
    logic          data_ready;

    ddr3_frame_reader dut (
        .i_ddr3_clk         (clk),
        .i_rst_n            (rst_n),
        .i_rd_start         (rd_start),
        .i_rd_addr          (rd_addr),
        .i_rd_len           (rd_len),
        .o_rd_busy          (rd_busy),
        .o_rd_done          (rd_done),
        .o_rd_err           (rd_err),
        .o_ddr3_cmd         (ddr3_cmd),
        .o_ddr3_cmd_en      (ddr3_cmd_en),
        .o_ddr3_addr        (ddr3_addr),
        .i_ddr3_cmd_ready   (ddr3_cmd_ready),
        .i_ddr3_rd_data     (ddr3_rd_data),
        .i_ddr3_rd_data_de  (ddr3_rd_de),
        .i_ddr3_rd_data_end (ddr3_rd_end),
        .o_data             (data),
        .o_data_valid       (data_valid),
        .o_data_last        (data_last),
        .i_data_ready       (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [127:0] d; logic last; } beat_t;
    typedef struct { logic [27:0] a; int due; } pend_t;

    beat_t       exp_q[$];
    logic [27:0] cmd_q[$];
    pend_t       pend_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, lat = 2, cmd_pct = 100, dat_pct = 100;
    int cmd_cnt = 0, done_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic         prev_last;

    function automatic logic [127:0] mem_word(input logic [27:0] a);
        logic [31:0] x;
        x = {4'h0, a};
        return {x * 32'h9E3779B1, x ^ 32'hDEADBEEF, x + 32'h01234567, ~x};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // DDR3 IP model: accepts commands seen at the negedge, returns the stored word lat cycles later, in order.
    always begin
        @(negedge clk);
        if (rst_n && ddr3_cmd_en) begin
            cmd_cnt++;
            check("cmd_code", 128'(ddr3_cmd), 128'(CMD_RD));
            if (cmd_q.size() == 0) fail_now("unexpected_cmd");
            else check("cmd_addr", 128'(ddr3_addr), 128'(cmd_q.pop_front()));
            pend_q.push_back('{ddr3_addr, cyc + lat});
        end
        @(posedge clk);
        #1;
        cyc++;
        ddr3_cmd_ready = ($urandom_range(99) < cmd_pct);
        data_ready     = ($urandom_range(99) < dat_pct);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            ddr3_rd_de   = 1'b1;
            ddr3_rd_end  = 1'b1;
            ddr3_rd_data = mem_word(pend_q[0].a);
            void'(pend_q.pop_front());
        end else begin
            ddr3_rd_de   = 1'b0;
            ddr3_rd_end  = 1'b0;
            ddr3_rd_data = '0;
        end
    end

    // Output monitor: compares accepted beats against the expected queue and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 128'(data_valid), 128'(1));
                check("hold_data", data, prev_data);
                check("hold_last", 128'(data_last), 128'(prev_last));
            end
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", data, e.d);
                    check("beat_last", 128'(data_last), 128'(e.last));
                end
            end
            prev_stall = data_valid & ~data_ready;
            prev_data  = data;
            prev_last  = data_last;
            if (rd_done) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_rd(input logic [27:0] a, input logic [15:0] l, input bit accept);
        @(posedge clk);
        #2;
        rd_start = 1'b1;
        rd_addr  = a;
        rd_len   = l;
        if (accept) begin
            for (int i = 0; i < int'(l); i++) begin
                logic [27:0] ai;
                ai = a + 28'(i * 8);
                cmd_q.push_back(ai);
                exp_q.push_back('{mem_word(ai), (i == int'(l) - 1)});
            end
        end
        @(posedge clk);
        #2;
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == base) fail_now({name, "_timeout"});
        repeat (3) @(posedge clk);
        check({name, "_done_once"}, 128'(done_cnt), 128'(base + 1));
        check({name, "_beats_left"}, 128'(exp_q.size()), 128'(0));
        check({name, "_cmds_left"}, 128'(cmd_q.size()), 128'(0));
        @(negedge clk);
        check({name, "_busy"}, 128'(rd_busy), 128'(0));
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_valid"}, 128'(data_valid), 128'(0));
        check({name, "_data"}, data, 128'(0));
        check({name, "_last"}, 128'(data_last), 128'(0));
        check({name, "_busy"}, 128'(rd_busy), 128'(0));
        check({name, "_done"}, 128'(rd_done), 128'(0));
        check({name, "_err"}, 128'(rd_err), 128'(0));
        check({name, "_cmd_en"}, 128'(ddr3_cmd_en), 128'(0));
        check({name, "_addr"}, 128'(ddr3_addr), 128'(0));
        check({name, "_cmd"}, 128'(ddr3_cmd), 128'(CMD_RD));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c0, n;
        rst_n = 1'b0;
        rd_start = 1'b0; rd_addr = '0; rd_len = '0;
        ddr3_cmd_ready = 1'b0; ddr3_rd_data = '0; ddr3_rd_de = 1'b0; ddr3_rd_end = 1'b0;
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Basic 4-beat read
        lat = 2; cmd_pct = 100; dat_pct = 100;
        base = done_cnt;
        start_rd(28'h100, 16'd4, 1'b1);
        wait_done("t1", base, 200);

        // Credit limit with downstream stalled
        dat_pct = 0;
        base = done_cnt; c0 = cmd_cnt;
        start_rd(28'h40000, 16'd64, 1'b1);
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("t2_cmds_at_credit", 128'(cmd_cnt - c0), 128'(32));
        check("t2_cmd_en_blocked", 128'(ddr3_cmd_en), 128'(0));
        dat_pct = 100;
        wait_done("t2", base, 500);
        check("t2_cmds_total", 128'(cmd_cnt - c0), 128'(64));

        // Address wrap
        base = done_cnt;
        start_rd(28'hFFFFFF8, 16'd3, 1'b1);
        wait_done("t3", base, 200);

        // Zero-length request
        c0 = cmd_cnt;
        start_rd(28'h3000, 16'd0, 1'b0);
        @(negedge clk);
        check("t4_zero_done", 128'(rd_done), 128'(1));
        check("t4_zero_busy", 128'(rd_busy), 128'(0));
        @(negedge clk);
        check("t4_zero_done_clr", 128'(rd_done), 128'(0));
        check("t4_zero_no_cmd", 128'(cmd_cnt - c0), 128'(0));

        // Start while busy is ignored
        cmd_pct = 0;
        base = done_cnt;
        start_rd(28'h2000, 16'd4, 1'b1);
        start_rd(28'h9000, 16'd7, 1'b0);
        @(negedge clk);
        check("t4_busy", 128'(rd_busy), 128'(1));
        check("t4_addr_kept", 128'(ddr3_addr), 128'(28'h2000));
        cmd_pct = 100;
        wait_done("t4", base, 200);

        // Random handshakes, 100 beats
        lat = 3; cmd_pct = 50; dat_pct = 50;
        base = done_cnt;
        start_rd(28'($urandom) & 28'hFFFFFF8, 16'd100, 1'b1);
        wait_done("t5", base, 4000);

        // Reset mid-transfer with three reads outstanding
        lat = 8; cmd_pct = 100; dat_pct = 100;
        c0 = cmd_cnt;
        start_rd(28'h500, 16'd8, 1'b1);
        n = 0;
        while (cmd_cnt - c0 < 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (cmd_cnt - c0 < 3) fail_now("t6_cmd_timeout");
        #2 rst_n = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        @(negedge clk);
        check_reset_outs("t6_rst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        while (pend_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (pend_q.size() > 0) fail_now("t6_stale_timeout");
        repeat (3) @(negedge clk);
        check("t6_err", 128'(rd_err), 128'(1));
        check("t6_valid", 128'(data_valid), 128'(0));
        check("t6_busy", 128'(rd_busy), 128'(0));
        check("t6_cmd_en", 128'(ddr3_cmd_en), 128'(0));

        // New transfer clears the error flag
        lat = 2;
        base = done_cnt;
        start_rd(28'h700, 16'd2, 1'b1);
        @(negedge clk);
        check("t7_err_cleared", 128'(rd_err), 128'(0));
        wait_done("t7", base, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
